// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter for one shared 32-bit little-endian memory.
// Each access is held on the memory pins for WAIT_CYC cycles and then acknowledged for one cycle.
module mem_arbiter #(
  parameter int WAIT_CYC     = 1,
  parameter int MAX_D_STREAK = 4,
  parameter int MEM_BYTES    = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic        i_ack,
  output logic        i_err,
  output logic [31:0] i_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  input  logic [31:0] mem_rd,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

  localparam int WW = (WAIT_CYC > 1) ? $clog2(WAIT_CYC) : 1;
  localparam int SW = $clog2(MAX_D_STREAK + 1);

  state_t        state;
  logic [WW-1:0] wcnt;
  logic [SW-1:0] streak;
  logic          port_d;
  logic          we_q;

  logic          gnt_d;
  logic          sel_we;
  logic          sel_bad;
  logic [31:0]   sel_addr;

  // Data wins unless fetch has been passed over MAX_D_STREAK times in a row.
  always_comb begin
    gnt_d    = d_req && !(i_req && (streak == SW'(MAX_D_STREAK)));
    sel_addr = gnt_d ? d_addr : i_addr;
    sel_we   = gnt_d && d_we;
    sel_bad  = (sel_addr[1:0] != 2'b00) || (sel_addr > 32'(MEM_BYTES - 4));
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wcnt      <= '0;
      streak    <= '0;
      port_d    <= 1'b0;
      we_q      <= 1'b0;
      i_ack     <= 1'b0;
      i_err     <= 1'b0;
      i_rdata   <= '0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= '0;
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wd    <= '0;
    end else begin
      i_ack <= 1'b0;
      d_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (i_req || d_req) begin
            port_d <= gnt_d;
            we_q   <= sel_we;
            wcnt   <= '0;
            if (gnt_d && i_req && (streak != SW'(MAX_D_STREAK))) streak <= streak + 1'b1;
            else if (!(gnt_d && i_req))                           streak <= '0;
            if (sel_bad) begin
              // Illegal address: skip the memory entirely and report the error.
              state <= ACK;
              if (gnt_d) begin
                d_ack   <= 1'b1;
                d_err   <= 1'b1;
                d_rdata <= '0;
              end else begin
                i_ack   <= 1'b1;
                i_err   <= 1'b1;
                i_rdata <= '0;
              end
            end else begin
              state     <= BUSY;
              mem_addr  <= sel_addr;
              mem_read  <= !sel_we;
              mem_write <= sel_we && (WAIT_CYC == 1);
              mem_wd    <= sel_we ? d_wdata : '0;
            end
          end
        end
        BUSY: begin
          if (wcnt == WW'(WAIT_CYC - 1)) begin
            state     <= ACK;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wd    <= '0;
            if (port_d) begin
              d_ack <= 1'b1;
              d_err <= 1'b0;
              if (!we_q) d_rdata <= mem_rd;
            end else begin
              i_ack   <= 1'b1;
              i_err   <= 1'b0;
              i_rdata <= mem_rd;
            end
          end else begin
            wcnt      <= wcnt + 1'b1;
            // Write strobe only in the last held cycle so the memory sees one write edge.
            mem_write <= we_q && (wcnt == WW'(WAIT_CYC - 2));
          end
        end
        ACK: begin
          state <= IDLE;
          i_err <= 1'b0;
          d_err <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: WAIT_CYC=1 instance with a scoreboard and vector table,
// plus a WAIT_CYC=3 instance for wait-state timing.
module tb_mem_arbiter;

  logic clk, rst_n;
  logic i_req, i_ack, i_err, d_req, d_we, d_ack, d_err;
  logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
  logic mem_read, mem_write, busy;
  logic [31:0] mem_addr, mem_wd, mem_rd;

  logic u2_i_req, u2_i_ack, u2_i_err, u2_d_req, u2_d_we, u2_d_ack, u2_d_err;
  logic [31:0] u2_i_addr, u2_i_rdata, u2_d_addr, u2_d_wdata, u2_d_rdata;
  logic u2_mem_read, u2_mem_write, u2_busy;
  logic [31:0] u2_mem_addr, u2_mem_wd, u2_mem_rd;

  mem_arbiter #(.WAIT_CYC(1), .MAX_D_STREAK(4), .MEM_BYTES(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_err(i_err), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wd(mem_wd), .mem_rd(mem_rd), .busy(busy));

  mem_arbiter #(.WAIT_CYC(3), .MAX_D_STREAK(4), .MEM_BYTES(1024)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .i_req(u2_i_req), .i_addr(u2_i_addr), .i_ack(u2_i_ack), .i_err(u2_i_err), .i_rdata(u2_i_rdata),
    .d_req(u2_d_req), .d_we(u2_d_we), .d_addr(u2_d_addr), .d_wdata(u2_d_wdata),
    .d_ack(u2_d_ack), .d_err(u2_d_err), .d_rdata(u2_d_rdata),
    .mem_read(u2_mem_read), .mem_write(u2_mem_write), .mem_addr(u2_mem_addr),
    .mem_wd(u2_mem_wd), .mem_rd(u2_mem_rd), .busy(u2_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Byte memories behind each instance, plus a preload port driven by the bench.
  logic [7:0] mem [0:1023];
  logic [7:0] mem2 [0:1023];
  logic       ld_en, ld_sel;
  logic [9:0] ld_a, ma, ma2;
  logic [31:0] ld_d;
  assign ma  = mem_addr[9:0];
  assign ma2 = u2_mem_addr[9:0];
  assign mem_rd    = {mem[ma + 10'd3], mem[ma + 10'd2], mem[ma + 10'd1], mem[ma]};
  assign u2_mem_rd = {mem2[ma2 + 10'd3], mem2[ma2 + 10'd2], mem2[ma2 + 10'd1], mem2[ma2]};

  always @(posedge clk) begin
    if (ld_en && !ld_sel) begin
      mem[ld_a] <= ld_d[7:0]; mem[ld_a + 10'd1] <= ld_d[15:8];
      mem[ld_a + 10'd2] <= ld_d[23:16]; mem[ld_a + 10'd3] <= ld_d[31:24];
    end else if (mem_write) begin
      mem[ma] <= mem_wd[7:0]; mem[ma + 10'd1] <= mem_wd[15:8];
      mem[ma + 10'd2] <= mem_wd[23:16]; mem[ma + 10'd3] <= mem_wd[31:24];
    end
  end

  always @(posedge clk) begin
    if (ld_en && ld_sel) begin
      mem2[ld_a] <= ld_d[7:0]; mem2[ld_a + 10'd1] <= ld_d[15:8];
      mem2[ld_a + 10'd2] <= ld_d[23:16]; mem2[ld_a + 10'd3] <= ld_d[31:24];
    end else if (u2_mem_write) begin
      mem2[ma2] <= u2_mem_wd[7:0]; mem2[ma2 + 10'd1] <= u2_mem_wd[15:8];
      mem2[ma2 + 10'd2] <= u2_mem_wd[23:16]; mem2[ma2 + 10'd3] <= u2_mem_wd[31:24];
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct { bit port; logic [31:0] rdata; bit err; bit chk_rd; } exp_t;
  exp_t sbq[$];

  // Scoreboard: every ack on the WAIT_CYC=1 instance must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && (i_ack || d_ack)) begin
      exp_t e;
      chk("single_ack", {31'd0, i_ack & d_ack}, 32'd0);
      chk("sb_nonempty", {31'd0, sbq.size() != 0}, 32'd1);
      if (sbq.size() != 0) begin
        e = sbq.pop_front();
        chk("ack_port", {31'd0, d_ack}, {31'd0, e.port});
        chk("ack_err", {31'd0, d_ack ? d_err : i_err}, {31'd0, e.err});
        if (e.chk_rd) chk("ack_rdata", d_ack ? d_rdata : i_rdata, e.rdata);
      end
    end
  end

  typedef struct {
    bit port; bit we; logic [31:0] addr; logic [31:0] wdata;
    logic [31:0] rdata; bit err; int lat;
  } vec_t;

  task automatic ld(input bit sel, input logic [9:0] a, input logic [31:0] d);
    @(negedge clk); ld_en = 1'b1; ld_sel = sel; ld_a = a; ld_d = d;
    @(negedge clk); ld_en = 1'b0;
  endtask

  task automatic do_access(input vec_t v);
    exp_t e;
    int lat, rdc, wrc, bad;
    bit got;
    e.port = v.port; e.rdata = v.rdata; e.err = v.err; e.chk_rd = !v.we;
    sbq.push_back(e);
    @(negedge clk);
    if (v.port) begin d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata; end
    else begin i_req = 1'b1; i_addr = v.addr; end
    @(posedge clk);
    lat = 0; rdc = 0; wrc = 0; bad = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk); lat++;
      if (mem_read) rdc++;
      if (mem_write) wrc++;
      if (mem_write && mem_wd !== v.wdata) bad++;
      if ((mem_read || mem_write) && mem_addr !== v.addr) bad++;
      got = v.port ? d_ack : i_ack;
    end
    i_req = 1'b0; d_req = 1'b0;
    chk("latency", lat, v.lat);
    chk("read_cycles", rdc, (!v.err && !v.we) ? 1 : 0);
    chk("write_cycles", wrc, (!v.err && v.we) ? 1 : 0);
    chk("mem_pins", bad, 0);
  endtask

  task automatic acc2(input bit port, input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                      input bit drop, output int lat, output int rdc, output int wrc,
                      output int wpos, output int bsy);
    bit got;
    int bad;
    @(negedge clk);
    if (port) begin u2_d_req = 1'b1; u2_d_we = we; u2_d_addr = addr; u2_d_wdata = wdata; end
    else begin u2_i_req = 1'b1; u2_i_addr = addr; end
    @(posedge clk);
    lat = 0; rdc = 0; wrc = 0; wpos = 0; bsy = 0; bad = 0; got = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk); lat++;
      if (drop) begin u2_i_req = 1'b0; u2_d_req = 1'b0; end
      if (u2_mem_read) rdc++;
      if (u2_mem_write) begin wrc++; wpos = lat; end
      if (u2_mem_write && u2_mem_wd !== wdata) bad++;
      if ((u2_mem_read || u2_mem_write) && u2_mem_addr !== addr) bad++;
      if (u2_busy) bsy++;
      got = port ? u2_d_ack : u2_i_ack;
    end
    u2_i_req = 1'b0; u2_d_req = 1'b0;
    @(negedge clk);
    if (u2_busy) bsy++;
    chk("u2_mem_pins", bad, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[11];
    int lat, rdc, wrc, wpos, bsy, n, cyc;
    bit order[10];
    exp_t e;

    rst_n = 1'b0; ld_en = 1'b0; ld_sel = 1'b0; ld_a = '0; ld_d = '0;
    i_req = 0; i_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
    u2_i_req = 0; u2_i_addr = 0; u2_d_req = 0; u2_d_we = 0; u2_d_addr = 0; u2_d_wdata = 0;

    ld(1'b0, 10'd4, 32'h11223344);
    ld(1'b0, 10'd8, 32'h55667788);
    ld(1'b0, 10'd1020, 32'hCAFEF00D);
    ld(1'b1, 10'd0, 32'hA5A55A5A);

    chk("rst_ctl", {25'd0, i_ack, i_err, d_ack, d_err, mem_read, mem_write, busy}, 32'd0);
    chk("rst_rdata", i_rdata | d_rdata, 32'd0);
    chk("rst_pins", mem_addr | mem_wd, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Reset during the only (final) write cycle must suppress the write and the ack.
    @(negedge clk); d_req = 1'b1; d_we = 1'b1; d_addr = 32'd8; d_wdata = 32'hFFFF0000;
    @(posedge clk); @(negedge clk);
    chk("rstw_pre_write", {31'd0, mem_write}, 32'd1);
    rst_n = 1'b0; #1;
    chk("rstw_write_drop", {31'd0, mem_write}, 32'd0);
    chk("rstw_busy", {31'd0, busy}, 32'd0);
    @(posedge clk); @(negedge clk); d_req = 1'b0; d_we = 1'b0; rst_n = 1'b1;
    chk("rstw_mem8", {mem[11], mem[10], mem[9], mem[8]}, 32'h55667788);
    n = 0;
    repeat (3) begin @(negedge clk); if (d_ack) n++; end
    chk("rstw_no_ack", n, 0);

    tbl[0]  = '{1'b0, 1'b0, 32'd4,    32'd0,        32'h11223344, 1'b0, 2};
    tbl[1]  = '{1'b1, 1'b1, 32'd16,   32'hDEADBEEF, 32'd0,        1'b0, 2};
    tbl[2]  = '{1'b1, 1'b0, 32'd16,   32'd0,        32'hDEADBEEF, 1'b0, 2};
    tbl[3]  = '{1'b1, 1'b0, 32'd6,    32'd0,        32'd0,        1'b1, 1};
    tbl[4]  = '{1'b0, 1'b0, 32'd1024, 32'd0,        32'd0,        1'b1, 1};
    tbl[5]  = '{1'b0, 1'b0, 32'd1020, 32'd0,        32'hCAFEF00D, 1'b0, 2};
    tbl[6]  = '{1'b1, 1'b0, 32'd1021, 32'd0,        32'd0,        1'b1, 1};
    tbl[7]  = '{1'b1, 1'b1, 32'd0,    32'h01020304, 32'd0,        1'b0, 2};
    tbl[8]  = '{1'b1, 1'b1, 32'd1024, 32'h0BADF00D, 32'd0,        1'b1, 1};
    tbl[9]  = '{1'b1, 1'b0, 32'd0,    32'd0,        32'h01020304, 1'b0, 2};
    tbl[10] = '{1'b0, 1'b0, 32'd2,    32'd0,        32'd0,        1'b1, 1};
    for (int k = 0; k < 11; k++) do_access(tbl[k]);
    @(negedge clk);
    chk("d_rdata_held", d_rdata, 32'h01020304);
    chk("i_rdata_err_zero", i_rdata, 32'd0);
    chk("mem16", {mem[19], mem[18], mem[17], mem[16]}, 32'hDEADBEEF);

    // Both ports held: four data grants, then fetch is forced, twice over.
    order = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};
    for (int k = 0; k < 10; k++) begin
      e.port = order[k]; e.err = 1'b0; e.chk_rd = 1'b1;
      e.rdata = order[k] ? 32'hDEADBEEF : 32'h11223344;
      sbq.push_back(e);
    end
    @(negedge clk); i_req = 1'b1; i_addr = 32'd4; d_req = 1'b1; d_we = 1'b0; d_addr = 32'd16;
    n = 0; cyc = 0;
    while (n < 10 && cyc < 200) begin
      @(negedge clk); cyc++;
      if (i_ack || d_ack) n++;
    end
    i_req = 1'b0; d_req = 1'b0;
    chk("streak_acks", n, 10);
    chk("streak_cycles", cyc, 29);
    repeat (2) @(negedge clk);

    // Three wait cycles; the fetch requester drops its request mid-access.
    acc2(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, lat, rdc, wrc, wpos, bsy);
    chk("w3_rd_lat", lat, 4);
    chk("w3_rd_cycles", rdc, 3);
    chk("w3_rd_busy", bsy, 4);
    chk("w3_rd_data", u2_i_rdata, 32'hA5A55A5A);
    chk("w3_rd_err", {31'd0, u2_i_err}, 32'd0);
    acc2(1'b1, 1'b1, 32'd8, 32'h12345678, 1'b0, lat, rdc, wrc, wpos, bsy);
    chk("w3_wr_lat", lat, 4);
    chk("w3_wr_count", wrc, 1);
    chk("w3_wr_pos", wpos, 3);
    chk("w3_wr_noread", rdc, 0);
    acc2(1'b1, 1'b0, 32'd8, 32'd0, 1'b0, lat, rdc, wrc, wpos, bsy);
    chk("w3_rb_data", u2_d_rdata, 32'h12345678);
    chk("w3_rb_err", {31'd0, u2_d_err}, 32'd0);
    chk("w3_rb_cycles", rdc, 3);

    chk("sb_drained", sbq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
